exception_sequencer: RTL and testbench
======================================

Name: exception_sequencer

Overview:
- Multicycle sequencer that handles the CPU's three exception types: invalid opcode, arithmetic overflow and divide-by-zero.
- On an exception it saves EPC and takes ownership of the memory-address mux select (vector addresses 253/254/255).
- It waits out the memory read latency, then loads PC with the zero-extended handler byte.
- Sits directly upstream of the memory-address mux, beside the main control unit, which yields the mux while busy=1.

Parameters:
MEM_LATENCY, 2, cycles iord_sel is held before mem_data_in is valid; values <1 treated as 1
EPC_OFFSET, 4, amount subtracted from pc_in to form EPC (PC already incremented)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
exc_opcode  in  1  invalid-opcode request, level sampled each edge
exc_overflow  in  1  ALU overflow request
exc_div0  in  1  divide-by-zero request
pc_in  in  32  current (incremented) PC
mem_data_in  in  8  low byte of memory read data
busy  out  1  sequencer owns PC/EPC/mux; control unit must stall
iord_override  out  1  1 = iord_sel drives the address mux
iord_sel  out  3  mux select: 011=253 opcode, 100=254 overflow, 101=255 div0, 000 otherwise
epc_out  out  32  EPC write data
epc_wr  out  1  EPC write enable, one cycle
pc_out  out  32  PC write data {24'b0, mem_data_in}
pc_wr  out  1  PC write enable, one cycle
exc_cause  out  2  latched cause: 00 none, 01 opcode, 10 overflow, 11 div0
done  out  1  one-cycle pulse when handler entry complete
overrun  out  1  one-cycle pulse: request arrived while busy (dropped)

Behaviour:
- reset low (any time, async): state IDLE; all outputs 0; exc_cause=00; counter=0. An in-flight sequence is abandoned. No pc_wr/epc_wr is issued after reset deasserts.
- All outputs are registered/Moore, decoded from state and latched registers.
- IDLE:
  - Any request high at a rising edge latches the cause, then goes to SAVE.
  - Priority on simultaneous requests: opcode > overflow > div0.
  - The EPC value, pc_in − EPC_OFFSET (mod 2^32), is latched at that same edge.
- SAVE (1 cycle):
  - busy=1, epc_wr=1, epc_out=latched EPC.
  - iord_override=1 and iord_sel set from the cause from this cycle on.
  - Go to ADDR; counter loaded with MEM_LATENCY.
- ADDR (MEM_LATENCY cycles):
  - busy=1, iord_override=1, iord_sel held stable.
  - Counter decrements each cycle; leave to LOAD when it reaches 1 at an edge.
  - mem_data_in is captured at the exit edge.
- LOAD (1 cycle):
  - pc_wr=1, pc_out={24'b0, captured byte}.
  - iord_override=1, iord_sel still held.
- DONE (1 cycle):
  - done=1, busy=1, iord_override=0, iord_sel=000.
  - Next state is IDLE.
- Latency: request edge → epc_wr asserted next cycle → pc_wr asserted MEM_LATENCY+1 cycles after epc_wr → done one cycle later. Total busy = MEM_LATENCY+3 cycles.
- exc_cause holds its value after DONE until the next exception or reset.
- Any request high while state≠IDLE:
  - Ignored; overrun pulses for one cycle per edge at which a request is sampled.
  - A request still high in the IDLE cycle after DONE starts a new sequence (level-sensitive).
- EPC wrap: pc_in < EPC_OFFSET wraps, e.g. pc_in=0 → epc_out=0xFFFFFFFC.
- pc_in changes after latching do not affect epc_out.
- Outside SAVE/LOAD, epc_out/pc_out hold their last values; the enables are 0.

Test Plan:
- Reset then idle:
  - Stimulus: reset low mid-run.
  - Response: every output 0 immediately; after release with no requests, busy=0 and iord_sel=000 indefinitely.
- Overflow, MEM_LATENCY=2, pc_in=0x0000_0040, mem_data_in=0x9C:
  - Edge+1: epc_wr=1, epc_out=0x3C, iord_sel=100.
  - Edge+4: pc_wr=1, pc_out=0x0000_009C.
  - Edge+5: done=1; busy for 5 cycles total; exc_cause=10.
- Simultaneous opcode+div0:
  - Response: exc_cause=01, iord_sel=011 (address 253); div0 not serviced unless it is still high after DONE.
- Request during busy:
  - Stimulus: div0 pulsed in the ADDR cycle of an opcode sequence.
  - Response: overrun=1 for one cycle; the opcode sequence completes unchanged; no second sequence.
- EPC wrap:
  - Stimulus: pc_in=0x0000_0000, exc_div0.
  - Response: epc_out=0xFFFF_FFFC, iord_sel=101.
- Reset mid-ADDR:
  - Stimulus: reset asserted in the ADDR state.
  - Response: pc_wr never asserts, iord_override drops at once; a fresh request after release runs a full, normal sequence.

Source files
------------

// File: rtl/exception_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : exception_sequencer_if
// Brief   : Request/response bundle between the CPU datapath and the
//           exception sequencer.
// Rev     : 1.0
// ============================================================================
interface exception_sequencer_if;
  logic        exc_opcode;
  logic        exc_overflow;
  logic        exc_div0;
  logic [31:0] pc_in;
  logic [7:0]  mem_data_in;
  logic        busy;
  logic        iord_override;
  logic [2:0]  iord_sel;
  logic [31:0] epc_out;
  logic        epc_wr;
  logic [31:0] pc_out;
  logic        pc_wr;
  logic [1:0]  exc_cause;
  logic        done;
  logic        overrun;

  // Datapath side: raises requests, supplies PC and memory read data
  modport master (
    output exc_opcode, exc_overflow, exc_div0, pc_in, mem_data_in,
    input  busy, iord_override, iord_sel, epc_out, epc_wr,
           pc_out, pc_wr, exc_cause, done, overrun
  );

  modport slave (
    input  exc_opcode, exc_overflow, exc_div0, pc_in, mem_data_in,
    output busy, iord_override, iord_sel, epc_out, epc_wr,
           pc_out, pc_wr, exc_cause, done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/exception_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : exception_sequencer
// Brief   : Multicycle entry sequencer for opcode/overflow/div0 exceptions:
//           saves EPC, steers the address mux to the vector, loads PC.
// Rev     : 1.0
// ============================================================================
module exception_sequencer #(
  parameter int MEM_LATENCY = 2,
  parameter int EPC_OFFSET  = 4
) (
  input  wire                  clk,
  input  wire                  reset,
  exception_sequencer_if.slave bus
);

  localparam int c_lat   = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;
  localparam int c_cnt_w = $clog2(c_lat + 1);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_save = 3'd1;
  localparam logic [2:0] c_addr = 3'd2;
  localparam logic [2:0] c_load = 3'd3;
  localparam logic [2:0] c_done = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [1:0]         r_cause;
  logic [31:0]        r_epc;
  logic [7:0]         r_byte;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_overrun;
  logic               w_req;
  logic [1:0]         w_cause_new;
  logic [2:0]         w_sel;
  logic               w_cnt_last;

  assign w_req      = bus.exc_opcode | bus.exc_overflow | bus.exc_div0;
  assign w_cnt_last = (r_cnt == c_cnt_w'(1));

  // Fixed priority: opcode > overflow > div0
  always_comb begin
    w_cause_new = 2'b00;
    if (bus.exc_opcode)        w_cause_new = 2'b01;
    else if (bus.exc_overflow) w_cause_new = 2'b10;
    else if (bus.exc_div0)     w_cause_new = 2'b11;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_idle;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_req) w_next = c_save;
      c_save:  w_next = c_addr;
      c_addr:  if (w_cnt_last) w_next = c_load;
      c_load:  w_next = c_done;
      c_done:  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cause   <= 2'b00;
      r_epc     <= 32'd0;
      r_byte    <= 8'd0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= (r_state != c_idle) && w_req;
      case (r_state)
        c_idle: if (w_req) begin
          r_cause <= w_cause_new;
          r_epc   <= bus.pc_in - 32'(EPC_OFFSET);
        end
        c_save: r_cnt <= c_cnt_w'(c_lat);
        c_addr: begin
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (w_cnt_last) r_byte <= bus.mem_data_in;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_sel = 3'b000;
    case (r_cause)
      2'b01:   w_sel = 3'b011;
      2'b10:   w_sel = 3'b100;
      2'b11:   w_sel = 3'b101;
      default: w_sel = 3'b000;
    endcase
  end

  // Moore outputs; the mux is owned only from SAVE through LOAD
  always_comb begin
    bus.busy          = (r_state != c_idle);
    bus.epc_wr        = (r_state == c_save);
    bus.pc_wr         = (r_state == c_load);
    bus.done          = (r_state == c_done);
    bus.iord_override = (r_state == c_save) || (r_state == c_addr) || (r_state == c_load);
    bus.iord_sel      = bus.iord_override ? w_sel : 3'b000;
    bus.epc_out       = r_epc;
    bus.pc_out        = {24'd0, r_byte};
    bus.exc_cause     = r_cause;
    bus.overrun       = r_overrun;
  end

endmodule
`default_nettype wire

// File: tb/tb_exception_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_exception_sequencer
// Brief   : Directed self-checking bench for exception_sequencer.
// Rev     : 1.0
// ============================================================================
module tb_exception_sequencer;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  exception_sequencer_if bus ();

  exception_sequencer #(.MEM_LATENCY(2), .EPC_OFFSET(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"},     32'(bus.busy), 32'd0);
    chk({tag, " ovr"},      32'(bus.iord_override), 32'd0);
    chk({tag, " sel"},      32'(bus.iord_sel), 32'd0);
    chk({tag, " epc_out"},  bus.epc_out, 32'd0);
    chk({tag, " epc_wr"},   32'(bus.epc_wr), 32'd0);
    chk({tag, " pc_out"},   bus.pc_out, 32'd0);
    chk({tag, " pc_wr"},    32'(bus.pc_wr), 32'd0);
    chk({tag, " cause"},    32'(bus.exc_cause), 32'd0);
    chk({tag, " done"},     32'(bus.done), 32'd0);
    chk({tag, " overrun"},  32'(bus.overrun), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b0;
    bus.exc_opcode = 1'b0; bus.exc_overflow = 1'b0; bus.exc_div0 = 1'b0;
    bus.pc_in = 32'd0; bus.mem_data_in = 8'd0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle busy", 32'(bus.busy), 32'd0);
      chk("idle sel",  32'(bus.iord_sel), 32'd0);
    end

    // Overflow, pc=0x40, byte 0x9C
    bus.exc_overflow = 1'b1; bus.pc_in = 32'h40; bus.mem_data_in = 8'h9C;
    tick();
    chk("ov save epc_wr", 32'(bus.epc_wr), 32'd1);
    chk("ov save epc",    bus.epc_out, 32'h3C);
    chk("ov save sel",    32'(bus.iord_sel), 32'd4);
    chk("ov save ovr",    32'(bus.iord_override), 32'd1);
    chk("ov save busy",   32'(bus.busy), 32'd1);
    bus.exc_overflow = 1'b0; bus.pc_in = 32'h1234;
    tick();
    chk("ov addr1 epc_wr", 32'(bus.epc_wr), 32'd0);
    chk("ov addr1 epc",    bus.epc_out, 32'h3C);
    chk("ov addr1 sel",    32'(bus.iord_sel), 32'd4);
    tick();
    chk("ov addr2 pc_wr",  32'(bus.pc_wr), 32'd0);
    chk("ov addr2 busy",   32'(bus.busy), 32'd1);
    tick();
    chk("ov load pc_wr",   32'(bus.pc_wr), 32'd1);
    chk("ov load pc",      bus.pc_out, 32'h9C);
    chk("ov load sel",     32'(bus.iord_sel), 32'd4);
    tick();
    chk("ov done done",    32'(bus.done), 32'd1);
    chk("ov done busy",    32'(bus.busy), 32'd1);
    chk("ov done ovr",     32'(bus.iord_override), 32'd0);
    chk("ov done sel",     32'(bus.iord_sel), 32'd0);
    chk("ov done pc_wr",   32'(bus.pc_wr), 32'd0);
    tick();
    chk("ov idle busy",    32'(bus.busy), 32'd0);
    chk("ov idle done",    32'(bus.done), 32'd0);
    chk("ov idle cause",   32'(bus.exc_cause), 32'd2);
    chk("ov idle pc hold", bus.pc_out, 32'h9C);

    // Simultaneous opcode + div0: opcode wins, div0 dropped
    bus.exc_opcode = 1'b1; bus.exc_div0 = 1'b1; bus.pc_in = 32'h100; bus.mem_data_in = 8'h11;
    tick();
    chk("pri cause", 32'(bus.exc_cause), 32'd1);
    chk("pri sel",   32'(bus.iord_sel), 32'd3);
    chk("pri epc",   bus.epc_out, 32'hFC);
    bus.exc_opcode = 1'b0; bus.exc_div0 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pri done", 32'(bus.done), 32'd1);
    tick();
    chk("pri idle busy", 32'(bus.busy), 32'd0);
    tick();
    chk("pri no div0 seq", 32'(bus.busy), 32'd0);
    chk("pri cause hold",  32'(bus.exc_cause), 32'd1);

    // div0 pulsed in ADDR of an opcode sequence
    bus.exc_opcode = 1'b1; bus.pc_in = 32'h200; bus.mem_data_in = 8'h55;
    tick();
    bus.exc_opcode = 1'b0;
    tick();
    chk("ovr addr1 overrun", 32'(bus.overrun), 32'd0);
    bus.exc_div0 = 1'b1;
    tick();
    chk("ovr pulse",    32'(bus.overrun), 32'd1);
    chk("ovr sel kept", 32'(bus.iord_sel), 32'd3);
    bus.exc_div0 = 1'b0;
    tick();
    chk("ovr pulse end", 32'(bus.overrun), 32'd0);
    chk("ovr load pc",   bus.pc_out, 32'h55);
    chk("ovr load pc_wr", 32'(bus.pc_wr), 32'd1);
    tick();
    chk("ovr done cause", 32'(bus.exc_cause), 32'd1);
    tick(); tick();
    chk("ovr no second seq", 32'(bus.busy), 32'd0);

    // EPC wrap with div0
    bus.exc_div0 = 1'b1; bus.pc_in = 32'h0;
    tick();
    chk("wrap epc",   bus.epc_out, 32'hFFFF_FFFC);
    chk("wrap sel",   32'(bus.iord_sel), 32'd5);
    chk("wrap cause", 32'(bus.exc_cause), 32'd3);
    // Held high: overrun each busy edge, then retrigger from IDLE
    tick(); tick(); tick(); tick();
    chk("lvl done overrun", 32'(bus.overrun), 32'd1);
    tick();
    chk("lvl idle busy", 32'(bus.busy), 32'd0);
    chk("lvl idle overrun", 32'(bus.overrun), 32'd1);
    tick();
    chk("lvl retrigger epc_wr", 32'(bus.epc_wr), 32'd1);
    chk("lvl retrigger overrun", 32'(bus.overrun), 32'd0);
    bus.exc_div0 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("lvl end busy", 32'(bus.busy), 32'd0);

    // Reset mid-ADDR
    bus.exc_overflow = 1'b1; bus.pc_in = 32'h80; bus.mem_data_in = 8'h77;
    tick();
    bus.exc_overflow = 1'b0;
    tick();
    chk("rst pre ovr", 32'(bus.iord_override), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_all_zero("rst async");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst held pc_wr", 32'(bus.pc_wr), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst post pc_wr", 32'(bus.pc_wr), 32'd0);
      chk("rst post busy",  32'(bus.busy), 32'd0);
    end

    // Fresh sequence after reset
    bus.exc_overflow = 1'b1; bus.pc_in = 32'h200; bus.mem_data_in = 8'hA5;
    tick();
    chk("fresh epc_wr", 32'(bus.epc_wr), 32'd1);
    chk("fresh epc",    bus.epc_out, 32'h1FC);
    bus.exc_overflow = 1'b0;
    tick(); tick(); tick();
    chk("fresh pc_wr", 32'(bus.pc_wr), 32'd1);
    chk("fresh pc",    bus.pc_out, 32'hA5);
    tick();
    chk("fresh done",  32'(bus.done), 32'd1);
    tick();
    chk("fresh idle",  32'(bus.busy), 32'd0);
    chk("fresh cause", 32'(bus.exc_cause), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
